// File: rtl/clk_divider_mc_if.sv
// Ratio-write bus for clk_divider_mc: a one-cycle strobe carrying the target
// channel and the new full-period divide ratio.
interface clk_divider_mc_if #(
    parameter int CH_W  = 1,
    parameter int DIV_W = 16
);
    logic             i_wr_en;
    logic [CH_W-1:0]  i_wr_ch;
    logic [DIV_W-1:0] i_wr_div;

    modport master (output i_wr_en, i_wr_ch, i_wr_div);
    modport slave  (input  i_wr_en, i_wr_ch, i_wr_div);
endinterface

// File: rtl/clk_divider_mc.sv
// Multi-channel programmable clock divider / tick generator with odd-ratio support
// and glitch-free ratio updates at period boundaries. Optional: CLK_DIVIDER_MC_SYNC_EN.
module clk_divider_mc_ch #(
    parameter int               DIV_W   = 16,
    parameter logic [DIV_W-1:0] DEF_DIV = 2
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pend
);
    localparam logic [DIV_W-1:0] RST_CNT = (DEF_DIV < DIV_W'(2)) ? '0 : DEF_DIV - DIV_W'(1);

    logic [DIV_W-1:0] div_q, div_d, pdiv_q, pdiv_d, cnt_q, cnt_d, div_nx;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
    logic [DIV_W:0]   cnt_inc, half;
    logic             wrap;

    // Widened by one bit so the ratio 2^DIV_W-1 still rounds up correctly.
    assign cnt_inc = {1'b0, cnt_q} + (DIV_W+1)'(1);
    assign half    = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
    assign wrap    = (div_q < DIV_W'(2)) || (cnt_q == div_q - DIV_W'(1));
    assign div_nx  = pend_q ? pdiv_q : div_q;

    always_comb begin
        div_d  = div_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (i_en) begin
            if (i_sync) begin
                div_d  = div_nx;
                pend_d = 1'b0;
                cnt_d  = '0;
                clk_d  = 1'b1;
                tick_d = 1'b1;
            end else if (wrap) begin
                div_d  = div_nx;
                pend_d = 1'b0;
                cnt_d  = '0;
                clk_d  = (div_nx >= DIV_W'(2));
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_inc[DIV_W-1:0];
                clk_d = (cnt_inc < half);
            end
        end
        // A write on the apply edge wins the pending flag, so it waits a full period.
        if (i_wr) begin
            pdiv_d = i_wr_div;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            div_q  <= DEF_DIV;
            pdiv_q <= '0;
            pend_q <= 1'b0;
            cnt_q  <= RST_CNT;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign o_clk  = clk_q;
    assign o_tick = tick_q;
    assign o_pend = pend_q;
endmodule

module clk_divider_mc #(
    parameter int FRECUENCY_IN  = 10,
    parameter int FRECUENCY_OUT = 5,
    parameter int NUM_CH        = 2,
    parameter int DIV_W         = 16,
    parameter int DEFAULT_DIV   = FRECUENCY_IN / FRECUENCY_OUT,
    parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 i_clk,
    input  logic                 rst,
    input  logic                 i_en,
`ifdef CLK_DIVIDER_MC_SYNC_EN
    input  logic                 i_sync,
`endif
    clk_divider_mc_if.slave      wr,
    output logic [NUM_CH-1:0]    o_clk,
    output logic [NUM_CH-1:0]    o_tick,
    output logic [NUM_CH-1:0]    o_pend
);
    logic sync;
`ifdef CLK_DIVIDER_MC_SYNC_EN
    assign sync = i_sync;
`else
    assign sync = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Channel codes at or above NUM_CH match no lane and are dropped.
        logic hit;
        assign hit = wr.i_wr_en && (wr.i_wr_ch == CH_W'(g));

        clk_divider_mc_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DIV_W'(DEFAULT_DIV))
        ) u_ch (
            .i_clk    (i_clk),
            .rst      (rst),
            .i_en     (i_en),
            .i_sync   (sync),
            .i_wr     (hit),
            .i_wr_div (wr.i_wr_div),
            .o_clk    (o_clk[g]),
            .o_tick   (o_tick[g]),
            .o_pend   (o_pend[g])
        );
    end
endmodule

// File: tb/tb_clk_divider_mc.sv
// Bench for clk_divider_mc: period-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_clk_divider_mc;
    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;
    localparam int CH_W   = 2;
    localparam int DEF    = 2;

    logic i_clk = 1'b0;
    logic rst   = 1'b1;
    logic en    = 1'b1;
    logic sync_r = 1'b0;
    logic [NUM_CH-1:0] o_clk, o_tick, o_pend;

    clk_divider_mc_if #(.CH_W(CH_W), .DIV_W(DIV_W)) wr_if ();

    clk_divider_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
        .i_clk  (i_clk),
        .rst    (rst),
        .i_en   (en),
`ifdef CLK_DIVIDER_MC_SYNC_EN
        .i_sync (sync_r),
`endif
        .wr     (wr_if.slave),
        .o_clk  (o_clk),
        .o_tick (o_tick),
        .o_pend (o_pend)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_mis = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: each channel tracks its position inside the current period.
    int md[NUM_CH], mp[NUM_CH], mpos[NUM_CH];
    bit mpend[NUM_CH];
    logic [NUM_CH-1:0] eclk, etick, epend;
    bit mdl_ok = 0;

    initial forever begin
        @(posedge i_clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                md[c] = DEF; mp[c] = 0; mpend[c] = 0;
                mpos[c] = (DEF >= 2) ? DEF - 1 : 0;
                eclk[c] = 1'b0; etick[c] = 1'b0;
            end else begin
                if (en) begin
                    if (sync_r) begin
                        if (mpend[c]) md[c] = mp[c];
                        mpend[c] = 0; mpos[c] = 0;
                        eclk[c] = 1'b1; etick[c] = 1'b1;
                    end else begin
                        if (md[c] < 2 || mpos[c] + 1 >= md[c]) begin
                            if (mpend[c]) md[c] = mp[c];
                            mpend[c] = 0; mpos[c] = 0;
                        end else begin
                            mpos[c] = mpos[c] + 1;
                        end
                        etick[c] = (mpos[c] == 0);
                        eclk[c]  = (md[c] >= 2) && (mpos[c] < (md[c] + 1) / 2);
                    end
                end else begin
                    etick[c] = 1'b0;
                end
                if (wr_if.i_wr_en && int'(wr_if.i_wr_ch) == c) begin
                    mp[c] = int'(wr_if.i_wr_div); mpend[c] = 1;
                end
            end
            epend[c] = mpend[c];
        end
        if (rst) mdl_ok = 1;
    end

    initial forever begin
        @(negedge i_clk);
        if (mdl_ok) begin
            chk("mdl_clk",  32'(o_clk),  32'(eclk));
            chk("mdl_tick", 32'(o_tick), 32'(etick));
            chk("mdl_pend", 32'(o_pend), 32'(epend));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic wr(input int ch, input int div);
        wr_if.i_wr_en  = 1'b1;
        wr_if.i_wr_ch  = CH_W'(ch);
        wr_if.i_wr_div = DIV_W'(div);
        cyc(1);
        wr_if.i_wr_en  = 1'b0;
    endtask

    task automatic wait_tick(input int ch);
        int k = 0;
        while (!o_tick[ch] && k < 100) begin cyc(1); k++; end
        chk("wait_tick", 32'(o_tick[ch]), 1);
    endtask

    task automatic wait_pend_clr(input int ch);
        int k = 0;
        while (o_pend[ch] && k < 100) begin cyc(1); k++; end
        chk("wait_pend_clr", 32'(o_pend[ch]), 0);
    endtask

    task automatic spacing(input int ch, output int n);
        n = 0;
        do begin cyc(1); n++; end while (!o_tick[ch] && n < 100);
    endtask

    initial begin
        int n, ticks, highs;
        bit ok;
        logic [5:0] pat;
        logic held;
        wr_if.i_wr_en = 1'b0; wr_if.i_wr_ch = '0; wr_if.i_wr_div = '0;

        cyc(3);
        chk("rst_clk",  32'(o_clk),  0);
        chk("rst_tick", 32'(o_tick), 0);
        chk("rst_pend", 32'(o_pend), 0);
        rst = 1'b0;
        cyc(1); chk("rel1_clk", 32'(o_clk), 3); chk("rel1_tick", 32'(o_tick), 3);
        cyc(1); chk("rel2_clk", 32'(o_clk), 0); chk("rel2_tick", 32'(o_tick), 0);
        cyc(1); chk("rel3_clk", 32'(o_clk), 3); chk("rel3_tick", 32'(o_tick), 3);

        wr(0, 5);
        chk("div5_pend", 32'(o_pend), 1);
        wait_tick(0);
        chk("div5_applied", 32'(o_pend[0]), 0);
        ticks = 0; highs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            ticks += int'(o_tick[0]);
            highs += int'(o_clk[0]);
        end
        chk("div5_ticks", ticks, 4);
        chk("div5_highs", highs, 12);

        wr(1, 1);
        wait_pend_clr(1);
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            ok &= o_tick[1] && !o_clk[1];
            cyc(1);
        end
        chk("bypass", 32'(ok), 1);
        wr(1, 4);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            pat = {pat[4:0], o_tick[1]};
            if (i < 5) cyc(1);
        end
        chk("bypass_to_4", 32'(pat), 32'b110001);

        cyc(1); wait_tick(0);
        wr(0, 3); wr(0, 7);
        wait_pend_clr(0);
        spacing(0, n); chk("overwrite_7", n, 7);

        cyc(6);
        wr(0, 6);
        chk("wrap_wr_tick", 32'(o_tick[0]), 1);
        chk("wrap_wr_pend", 32'(o_pend[0]), 1);
        spacing(0, n); chk("wrap_wr_old", n, 7);
        chk("wrap_wr_applied", 32'(o_pend[0]), 0);
        spacing(0, n); chk("wrap_wr_new", n, 6);

        wr(3, 9);
        chk("bad_ch", 32'(o_pend), 0);

        cyc(1); wait_tick(0);
        cyc(2);
        held = o_clk[0];
        en = 1'b0;
        ok = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            ok &= (o_tick == '0) && (o_clk[0] == held);
        end
        chk("freeze", 32'(ok), 1);
        en = 1'b1;
        n = 6;
        do begin cyc(1); n++; end while (!o_tick[0] && n < 100);
        chk("freeze_period", n, 10);

        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            wr_if.i_wr_en  = ($urandom_range(0, 3) == 0);
            wr_if.i_wr_ch  = CH_W'($urandom_range(0, 3));
            wr_if.i_wr_div = DIV_W'($urandom_range(0, 12));
`ifdef CLK_DIVIDER_MC_SYNC_EN
            sync_r = ($urandom_range(0, 19) == 0);
`endif
            cyc(1);
        end
        en = 1'b1; rst = 1'b0; wr_if.i_wr_en = 1'b0; sync_r = 1'b0;

        wr(0, 9);
        wait_pend_clr(0);
        wait_tick(0);
        cyc(3);
        wr(0, 5);
        chk("mid_pend", 32'(o_pend[0]), 1);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("mid_rst_pend", 32'(o_pend), 0);
        chk("mid_rst_clk", 32'(o_clk), 0);
        cyc(1); chk("mid_rel_clk", 32'(o_clk), 3); chk("mid_rel_tick", 32'(o_tick), 3);
        cyc(1); chk("mid_rel2_tick", 32'(o_tick), 0);

`ifdef CLK_DIVIDER_MC_SYNC_EN
        wr(0, 4); wr(1, 6);
        wait_pend_clr(0); wait_pend_clr(1);
        cyc(3);
        sync_r = 1'b1; cyc(1); sync_r = 1'b0;
        chk("sync_tick", 32'(o_tick), 3);
        chk("sync_clk",  32'(o_clk), 3);
        cyc(1);
        chk("sync_after", 32'(o_tick), 0);
`endif

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/clk_divider_mc.md
Name: clk_divider_mc

Overview:
Multi-channel, runtime-programmable clock divider and enable generator. It replaces the single fixed-ratio toggle divider.
- Each of NUM_CH channels derives a divided clock (`o_clk`) and a one-cycle enable strobe (`o_tick`) from `i_clk`.
- Odd ratios are supported.
- Ratio changes are glitch-free and take effect only at period boundaries.
- Sits next to the display/SPI timing logic, which consumes `o_tick` as a clock enable and `o_clk` as a pin-level clock.

Parameters:
- FRECUENCY_IN, 10, input clock frequency in Hz (integer).
- FRECUENCY_OUT, 5, default output frequency in Hz for all channels after reset.
- NUM_CH, 2, number of independent channels (≥1).
- DIV_W, 16, width of the divide-ratio field.
- DEFAULT_DIV, FRECUENCY_IN/FRECUENCY_OUT, reset divide ratio; must fit in DIV_W.
- CH_W, $clog2(NUM_CH) (minimum 1), width of the channel select.

Ports:
- i_clk, in, 1, sole clock; all logic on its rising edge.
- rst, in, 1, reset: synchronous, active-high.
- i_en, in, 1, global run enable; 0 freezes all channels.
- i_wr_en, in, 1, write strobe for a new ratio.
- i_wr_ch, in, CH_W, target channel for the write.
- i_wr_div, in, DIV_W, new divide ratio (full output period in `i_clk` cycles).
- o_clk, out, NUM_CH, divided clocks, registered.
- o_tick, out, NUM_CH, one-cycle strobe at each `o_clk` rising edge, registered.
- o_pend, out, NUM_CH, 1 while a written ratio is waiting to be applied.

Behaviour:
- Per channel: active ratio D, pending ratio P, pending flag, counter cnt (DIV_W bits).
- Reset (rst=1 at an edge):
  - D=DEFAULT_DIV, cnt=D-1 (0 if D<2), o_clk=0, o_tick=0, o_pend=0.
  - rst has priority over every other input.
- Divide mode (D≥2), i_en=1:
  - cnt advances 0,1,…,D-1, then wraps to 0.
  - o_clk=1 while the new cnt < ceil(D/2), else 0.
  - o_tick=1 only in the cycle cnt==0.
  - Odd D: high for (D+1)/2 cycles, low for (D-1)/2. Even D: exactly 50% duty.
- Reset release: the first edge after rst falls wraps cnt to 0, so o_clk and o_tick go to 1 on that edge. Outputs are registered with no extra latency beyond this.
- Bypass mode (D=0 or 1), i_en=1: o_tick=1 every cycle, o_clk held 0, cnt held 0.
- i_en=0:
  - cnt frozen, o_clk holds its value, o_tick forced 0.
  - Pending updates are not applied.
- Write (i_wr_en=1, i_wr_ch<NUM_CH): P=i_wr_div, pending flag=1 on that edge.
  - A second write before the update is applied overwrites P.
  - i_wr_ch≥NUM_CH: the write is ignored.
- Apply point: the edge where cnt wraps from D-1 to 0 (every enabled edge in bypass mode).
  - D=P, pending flag cleared, and the new period starts immediately with cnt=0 under the new D.
  - A write landing on the same edge as the wrap is not applied at that wrap; it waits for the next one.
- No partial periods: an o_clk high or low phase is never shortened or extended by a ratio change.
- Channels are fully independent; there is no phase relation between them except through the optional sync feature.
- Arithmetic: ceil(D/2) computed as (D+1)>>1 at DIV_W+1 bits, so D=2^DIV_W-1 does not overflow.

Optional Feature:
CLK_DIVIDER_MC_SYNC_EN.
- When defined: adds input `i_sync` (1 bit). On an edge with `i_sync`=1 (and rst=0, i_en=1), every channel:
  - applies any pending P;
  - sets cnt=0, o_clk=1, o_tick=1.
  - This realigns all channel phases in one cycle. `i_sync` has lower priority than rst and higher priority than normal counting.
- When not defined: the port is absent and channels align only at reset.

Test Plan:
- Reset, defaults (10/5 → D=2), NUM_CH=2: after rst release, both o_clk toggle 1,0,1,0 and o_tick=1 on every other cycle, starting on the first edge.
- Write ch0=5 mid-period: o_pend[0]=1 until the wrap; then the period is 5 cycles, o_clk high 3 / low 2, one o_tick per 5 cycles; ch1 is undisturbed.
- Bypass: write ch1=1 → after the current period, o_tick[1]=1 every cycle and o_clk[1]=0. Write ch1=4 → o_tick every 4th cycle, beginning the next cycle.
- Boundary and invalid writes:
  - Write ch0=3 then ch0=7 before the wrap → only 7 is applied.
  - Write ch0=6 exactly on the wrap edge → applied one period later.
  - Write i_wr_ch=3 with NUM_CH=2 → no change.
- i_en low for 4 cycles mid-phase: counters and o_clk freeze, o_tick=0. Resuming continues from the same cnt; the total period is stretched by exactly 4.
- Reset mid-operation (D=9, cnt=4, pending=1): rst for 1 cycle → D=DEFAULT_DIV, o_pend=0, restart as in the first scenario. With SYNC_EN: `i_sync` pulse while ch0=4 and ch1=6 → both o_tick=1 on the same edge.
